// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini SRC datapath: instruction fetch
// (T0-T2) followed by per-opcode execute steps (T3-T6).
module control_sequencer #(
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned OPW      = 5
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic        Run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        LOin,
    output logic        HIin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [3:0]  alu_op,
    output logic        instr_done,
    output logic        illegal,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_BIN, C_UNARY, C_MULDIV, C_NOP, C_HALT, C_ILLEGAL
    } op_class_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t        state;
    state_t        next_instr;
    logic [2:0]    wait_cnt;
    logic [OPW-1:0] opcode;
    op_class_t     op_class;
    logic [3:0]    op_alu;
    logic          unused_ir;

    assign opcode     = IR[31 -: OPW];
    assign unused_ir  = ^IR[31-OPW:0];
    assign next_instr = Run ? S_T0 : S_IDLE;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case statements can leave it unassigned (latch).
    always_comb begin
        op_class = C_ILLEGAL;
        op_alu   = 4'd0;
        case (opcode)
            OP_ADD:  begin op_class = C_BIN;    op_alu = 4'd1; end
            OP_SUB:  begin op_class = C_BIN;    op_alu = 4'd2; end
            OP_AND:  begin op_class = C_BIN;    op_alu = 4'd3; end
            OP_OR:   begin op_class = C_BIN;    op_alu = 4'd4; end
            OP_MUL:  begin op_class = C_MULDIV; op_alu = 4'd5; end
            OP_DIV:  begin op_class = C_MULDIV; op_alu = 4'd6; end
            OP_NEG:  begin op_class = C_UNARY;  op_alu = 4'd7; end
            OP_NOT:  begin op_class = C_UNARY;  op_alu = 4'd8; end
            OP_NOP:  op_class = C_NOP;
            OP_HALT: op_class = C_HALT;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
        end else begin
            case (state)
                S_IDLE: if (Run) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1: begin
                    // Hold T1 for the memory latency before moving on.
                    if (wait_cnt == WAIT_LAST) begin
                        state    <= S_T2;
                        wait_cnt <= 3'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_T2:   state <= S_T3;
                S_T3: begin
                    case (op_class)
                        C_BIN, C_UNARY, C_MULDIV: state <= S_T4;
                        C_HALT:                   state <= S_HALT;
                        default:                  state <= next_instr;
                    endcase
                end
                S_T4: begin
                    if (op_class == C_BIN || op_class == C_MULDIV) state <= S_T5;
                    else                                            state <= next_instr;
                end
                S_T5: begin
                    if (op_class == C_MULDIV) state <= S_T6;
                    else                      state <= next_instr;
                end
                S_T6:   state <= next_instr;
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from state and opcode rather than registered: IR is
    // only loaded at the end of T2, so T3 outputs cannot be precomputed.
    always_comb begin
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        PCin       = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        Gra        = 1'b0;
        Grb        = 1'b0;
        Grc        = 1'b0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        alu_op     = 4'd0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                PCin    = (wait_cnt == WAIT_LAST);
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    C_BIN: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    C_UNARY: begin
                        Grb    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = op_alu;
                    end
                    C_MULDIV: begin
                        Gra  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    C_ILLEGAL: begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                    default: instr_done = 1'b1;
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_BIN: begin
                        Grc    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = op_alu;
                    end
                    C_UNARY: begin
                        Zlowout    = 1'b1;
                        Gra        = 1'b1;
                        Rin        = 1'b1;
                        instr_done = 1'b1;
                    end
                    C_MULDIV: begin
                        Grb    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = op_alu;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    C_BIN: begin
                        Zlowout    = 1'b1;
                        Gra        = 1'b1;
                        Rin        = 1'b1;
                        instr_done = 1'b1;
                    end
                    C_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                if (op_class == C_MULDIV) begin
                    Zhighout   = 1'b1;
                    HIin       = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit for the Mini SRC datapath. It generates every datapath strobe that the datapath testbenches currently drive by hand: PCout, MARin, Zin, Zlowout, PCin, Read, MDRin, IRin, Yin, LOin, HIin, IncPC, ALU op and register selects.
- Runs fetch (T0–T2) followed by per-opcode execute steps (T3–T6) for register–register ALU, unary, multiply/divide, nop and halt instructions.
- Sits directly upstream of Datapath: consumes its IR output, drives its control inputs.

Parameters:
MEM_WAIT, 0, extra cycles T1 is held with Read/MDRin asserted (0..7) to cover memory latency.
OPW, 5, opcode field width, taken from IR[31:27].

Ports:
Clock  input  1  system clock; all state changes occur on the rising edge.
clear  input  1  asynchronous, active-low reset.
Run  input  1  1 = execute instructions; sampled only at instruction boundaries.
IR  input  32  datapath instruction register; opcode = IR[31:27], valid from T3 onward.
PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, LOin, HIin  output  1 each  datapath strobes.
Gra, Grb, Grc, Rin, Rout  output  1 each  register-field select and register-file in/out enables, consumed by the select-and-encode logic.
alu_op  output  4  ALU operation: 0 pass, 1 add, 2 sub, 3 and, 4 or, 5 mul, 6 div, 7 neg, 8 not.
instr_done  output  1  one-cycle pulse in the last execute step of every instruction.
illegal  output  1  one-cycle pulse in T3 when the opcode is undefined.
halted  output  1  high while in HALT.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs are decoded from the state register and the opcode only; no Mealy paths from Run.
- Reset (clear=0, asynchronous): state goes to IDLE, wait counter clears to 0, and all outputs are 0, including alu_op=0. A reset mid-instruction aborts the instruction immediately.
- IDLE: no outputs asserted. Run=1 → T0, otherwise stay in IDLE.
- T0: PCout, MARin, IncPC, Zin. Next state T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Wait counter counts MEM_WAIT extra cycles with the same outputs held.
  - PCin is asserted only on the final T1 cycle, so the PC increments exactly once.
  - Then → T2.
- T2: MDRout, IRin. Next state T3.
- Opcodes: add 00011, sub 00100, and 00101, or 00110, mul 01110, div 01111, neg 10000, not 10001, nop 11010, halt 11011. Any other opcode is illegal.
- Binary ops (add, sub, and, or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_op, Zin.
  - T5: Zlowout, Gra, Rin, instr_done.
- Unary ops (neg, not):
  - T3: Grb, Rout, alu_op, Zin.
  - T4: Zlowout, Gra, Rin, instr_done.
- mul, div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, alu_op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, instr_done.
- nop: T3 asserts instr_done only.
- Illegal opcode: T3 asserts illegal and instr_done; executes as nop.
- halt: T3 asserts instr_done, then → HALT. HALT asserts halted and no strobes, and is left only via clear.
- Last step (any state asserting instr_done except halt): Run=1 → T0, Run=0 → IDLE. Run is ignored in all other states; an instruction always completes once started.
- alu_op is 0 in every cycle that does not assert Zin during execute. It is also 0 during fetch: the datapath increments via IncPC.
- At most one of Gra/Grb/Grc and at most one bus driver (PCout, Zlowout, Zhighout, MDRout, Rout) is high in any cycle.

Test Plan:
- Reset then Run=1, IR=32'h18918000 (add R1,R2,R3), MEM_WAIT=0 → IDLE, T0–T5 over 6 cycles. T4 shows alu_op=1 with Grc, Rout and Zin; T5 shows Gra, Rin and instr_done; then T0.
- IR=32'h88918000 (not R1,R2) → T3 has Grb, Rout, alu_op=8 and Zin together; T4 has Zlowout, Gra, Rin and instr_done; total 5 cycles.
- IR=32'h70918000 (mul), Run dropped to 0 during T4 → sequence T3–T6 with LOin in T5 and HIin in T6; after T6 state goes to IDLE with all outputs 0.
- MEM_WAIT=3, any instruction → Read and MDRin high for 4 consecutive cycles; PCin high only in the 4th.
- IR opcode 11111 → illegal pulses once in T3, no Rin asserted; IR opcode 11011 → halted=1 and stays 1 for 20 cycles regardless of Run, until clear=0.
- Assert clear=0 asynchronously midway through T4 of an add → outputs go to 0 without waiting for a clock edge, no Rin occurs, and state is IDLE.
